// File: rtl/axis2fifo_pack_if.sv
// Purpose: bundles the AXIS sink handshake and the FIFO write port of axis2fifo_pack.
// Latency: none (wires only).
// Backpressure: axis_tready from the sink, fifo_full from the FIFO side.
// Ports: master = stream source plus FIFO status (drives tdata/tvalid/tlast/fifo_full);
//        slave  = the packer (drives tready/fifo_wdata/fifo_write).
interface axis2fifo_pack_if #(
    parameter int AXIS_DATA_W = 8,
    parameter int FIFO_DATA_W = 32
);
    logic [AXIS_DATA_W-1:0] axis_tdata;
    logic                   axis_tvalid;
    logic                   axis_tready;
    logic                   axis_tlast;
    logic                   fifo_full;
    logic [FIFO_DATA_W-1:0] fifo_wdata;
    logic                   fifo_write;

    modport master (
        output axis_tdata, axis_tvalid, axis_tlast, fifo_full,
        input  axis_tready, fifo_wdata, fifo_write
    );

    modport slave (
        input  axis_tdata, axis_tvalid, axis_tlast, fifo_full,
        output axis_tready, fifo_wdata, fifo_write
    );
endinterface

// File: rtl/axis2fifo_pack.sv
// Purpose: receives one AXIS frame, packs RATIO beats per FIFO word (lane 0 in LSBs), zero-pads the last word.
// Latency: FIFO write one cycle after the completing beat; done_o two cycles after the final word completes.
// Backpressure: tready drops the same cycle a pending word meets fifo_full; partial pack register is unaffected.
// Ports: clk_i/cke_i/arst_n_i/rst_i clocking and resets; en_i accept enable; max_len_i frame limit (0 = none);
//        len_o beats accepted, done_o/truncated_o sticky status; bus = AXIS sink + FIFO write port.
module axis2fifo_pack #(
    parameter int AXIS_DATA_W = 8,
    parameter int FIFO_DATA_W = 32,
    parameter int LEN_W       = 16
) (
    input  logic             clk_i,
    input  logic             cke_i,
    input  logic             arst_n_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [LEN_W-1:0] max_len_i,
    output logic [LEN_W-1:0] len_o,
    output logic             done_o,
    output logic             truncated_o,
    axis2fifo_pack_if.slave  bus
);
    localparam int RATIO = FIFO_DATA_W / AXIS_DATA_W;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q;
    logic [FIFO_DATA_W-1:0] pack_q;
    logic [FIFO_DATA_W-1:0] out_q;
    logic                   pend_q;
    logic [LEN_W-1:0]       len_q;
    logic                   trunc_q;

    logic [FIFO_DATA_W-1:0] merged;
    logic                   accept;
    logic                   max_hit;
    logic                   word_done;
    logic                   eof;
    logic                   wr;

    assign bus.axis_tready = en_i & (state_q == RUN) & (~pend_q | ~bus.fifo_full);
    assign accept          = bus.axis_tvalid & bus.axis_tready & cke_i;

    // Widened by one bit so a saturated len_q never aliases onto a small max_len_i.
    assign max_hit   = (max_len_i != '0) &&
                       (({1'b0, len_q} + 1'b1) == {1'b0, max_len_i});
    assign word_done = accept & ((idx_q == IDX_W'(RATIO - 1)) | bus.axis_tlast | max_hit);
    assign eof       = accept & (bus.axis_tlast | max_hit);

    // The write strobe is qualified by cke_i: while the clock is disabled pend_q
    // cannot clear, so an unqualified strobe would write the same word twice.
    assign wr              = pend_q & ~bus.fifo_full & cke_i;
    assign bus.fifo_write  = wr;
    assign bus.fifo_wdata  = out_q;

    assign len_o       = len_q;
    assign done_o      = (state_q == DONE);
    assign truncated_o = trunc_q;

    // Current beat dropped into its lane; lanes above idx are still zero because
    // the pack register is cleared on every word completion.
    always_comb begin
        merged = pack_q;
        for (int l = 0; l < RATIO; l++) begin
            if (idx_q == IDX_W'(l)) begin
                merged[l*AXIS_DATA_W +: AXIS_DATA_W] = bus.axis_tdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (eof) state_d = FLUSH;
            FLUSH:   if (wr)  state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase
    end

    // rst_i is honoured regardless of cke_i so a soft reset always lands.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= RUN;
            idx_q   <= '0;
            pack_q  <= '0;
            out_q   <= '0;
            pend_q  <= 1'b0;
            len_q   <= '0;
            trunc_q <= 1'b0;
        end else if (rst_i) begin
            state_q <= RUN;
            idx_q   <= '0;
            pack_q  <= '0;
            out_q   <= '0;
            pend_q  <= 1'b0;
            len_q   <= '0;
            trunc_q <= 1'b0;
        end else if (cke_i) begin
            state_q <= state_d;
            if (word_done) begin
                // Reload wins over a same-cycle write so back-to-back words never bubble.
                out_q  <= merged;
                pend_q <= 1'b1;
                pack_q <= '0;
                idx_q  <= '0;
            end else begin
                if (wr) begin
                    pend_q <= 1'b0;
                end
                if (accept) begin
                    pack_q <= merged;
                    idx_q  <= idx_q + 1'b1;
                end
            end
            if (accept && (len_q != '1)) begin
                len_q <= len_q + 1'b1;
            end
            if (eof && max_hit && !bus.axis_tlast) begin
                trunc_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_axis2fifo_pack.sv
module tb_axis2fifo_pack;
    logic        clk = 1'b0;
    logic        cke;
    logic        arst_n;
    logic        rst;
    logic        en;
    logic        en1;
    logic [15:0] max_len;
    logic [15:0] len4, len1;
    logic        done4, done1, trunc4, trunc1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    axis2fifo_pack_if #(.AXIS_DATA_W(8), .FIFO_DATA_W(32)) bus4 ();
    axis2fifo_pack_if #(.AXIS_DATA_W(8), .FIFO_DATA_W(8))  bus1 ();

    axis2fifo_pack #(.AXIS_DATA_W(8), .FIFO_DATA_W(32), .LEN_W(16)) dut4 (
        .clk_i(clk), .cke_i(cke), .arst_n_i(arst_n), .rst_i(rst), .en_i(en),
        .max_len_i(max_len), .len_o(len4), .done_o(done4), .truncated_o(trunc4),
        .bus(bus4)
    );

    axis2fifo_pack #(.AXIS_DATA_W(8), .FIFO_DATA_W(8), .LEN_W(16)) dut1 (
        .clk_i(clk), .cke_i(cke), .arst_n_i(arst_n), .rst_i(rst), .en_i(en1),
        .max_len_i(16'd0), .len_o(len1), .done_o(done1), .truncated_o(trunc1),
        .bus(bus1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [7:0]  dat;
        logic        last;
        logic        full;
        logic        exp_rdy;
        logic        exp_wr;
        logic [31:0] exp_wdata;
        logic [15:0] exp_len;
        logic        exp_done;
        logic        exp_trunc;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic vld, logic [7:0] dat, logic last, logic full,
                                logic rdy, logic wr, logic [31:0] wd,
                                logic [15:0] len, logic done, logic trunc);
        vec_t v;
        v.vld = vld; v.dat = dat; v.last = last; v.full = full;
        v.exp_rdy = rdy; v.exp_wr = wr; v.exp_wdata = wd;
        v.exp_len = len; v.exp_done = done; v.exp_trunc = trunc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
        else pass_cnt++;
    endtask

    // Each vector is driven at the falling edge and checked 1 ns later, before the rising edge.
    task automatic run_vecs(input string tag);
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            bus4.axis_tvalid = vq[i].vld;
            bus4.axis_tdata  = vq[i].dat;
            bus4.axis_tlast  = vq[i].last;
            bus4.fifo_full   = vq[i].full;
            #1;
            chk($sformatf("%s[%0d] tready", tag, i), 32'(bus4.axis_tready), 32'(vq[i].exp_rdy));
            chk($sformatf("%s[%0d] write", tag, i), 32'(bus4.fifo_write), 32'(vq[i].exp_wr));
            if (vq[i].exp_wr) chk($sformatf("%s[%0d] wdata", tag, i), bus4.fifo_wdata, vq[i].exp_wdata);
            chk($sformatf("%s[%0d] len", tag, i), 32'(len4), 32'(vq[i].exp_len));
            chk($sformatf("%s[%0d] done", tag, i), 32'(done4), 32'(vq[i].exp_done));
            chk($sformatf("%s[%0d] trunc", tag, i), 32'(trunc4), 32'(vq[i].exp_trunc));
        end
        vq.delete();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " tready"}, 32'(bus4.axis_tready), 32'd0);
        chk({tag, " write"},  32'(bus4.fifo_write),  32'd0);
        chk({tag, " wdata"},  bus4.fifo_wdata,       32'd0);
        chk({tag, " len"},    32'(len4),             32'd0);
        chk({tag, " done"},   32'(done4),            32'd0);
        chk({tag, " trunc"},  32'(trunc4),           32'd0);
    endtask

    task automatic idle_inputs();
        en = 1'b0;
        bus4.axis_tvalid = 1'b0;
        bus4.axis_tdata  = 8'h00;
        bus4.axis_tlast  = 1'b0;
        bus4.fifo_full   = 1'b0;
    endtask

    task automatic hard_rst(input string tag);
        @(negedge clk);
        idle_inputs();
        arst_n = 1'b0;
        #1;
        chk_reset(tag);
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic soft_rst(input string tag);
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset(tag);
    endtask

    initial begin
        cke = 1'b1; rst = 1'b0; arst_n = 1'b0; en1 = 1'b0; max_len = 16'd0;
        idle_inputs();
        bus1.axis_tvalid = 1'b0; bus1.axis_tdata = 8'h00; bus1.axis_tlast = 1'b0; bus1.fifo_full = 1'b0;
        #1;
        chk_reset("por");
        chk("por r1 write", 32'(bus1.fifo_write), 32'd0);
        chk("por r1 len", 32'(len1), 32'd0);
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;

        // Full 8-beat frame, two complete words.
        en = 1'b1;
        vq.push_back(mk(1, 8'h01, 0, 0, 1, 0, 32'h0, 0, 0, 0));
        vq.push_back(mk(1, 8'h02, 0, 0, 1, 0, 32'h0, 1, 0, 0));
        vq.push_back(mk(1, 8'h03, 0, 0, 1, 0, 32'h0, 2, 0, 0));
        vq.push_back(mk(1, 8'h04, 0, 0, 1, 0, 32'h0, 3, 0, 0));
        vq.push_back(mk(1, 8'h05, 0, 0, 1, 1, 32'h04030201, 4, 0, 0));
        vq.push_back(mk(1, 8'h06, 0, 0, 1, 0, 32'h0, 5, 0, 0));
        vq.push_back(mk(1, 8'h07, 0, 0, 1, 0, 32'h0, 6, 0, 0));
        vq.push_back(mk(1, 8'h08, 1, 0, 1, 0, 32'h0, 7, 0, 0));
        vq.push_back(mk(0, 8'h00, 0, 0, 0, 1, 32'h08070605, 8, 0, 0));
        vq.push_back(mk(0, 8'h00, 0, 0, 0, 0, 32'h0, 8, 1, 0));
        vq.push_back(mk(0, 8'h00, 0, 0, 0, 0, 32'h0, 8, 1, 0));
        run_vecs("t1_full");

        // 6-beat frame: zero-padded partial word.
        soft_rst("srst");
        en = 1'b1;
        vq.push_back(mk(1, 8'h01, 0, 0, 1, 0, 32'h0, 0, 0, 0));
        vq.push_back(mk(1, 8'h02, 0, 0, 1, 0, 32'h0, 1, 0, 0));
        vq.push_back(mk(1, 8'h03, 0, 0, 1, 0, 32'h0, 2, 0, 0));
        vq.push_back(mk(1, 8'h04, 0, 0, 1, 0, 32'h0, 3, 0, 0));
        vq.push_back(mk(1, 8'h05, 0, 0, 1, 1, 32'h04030201, 4, 0, 0));
        vq.push_back(mk(1, 8'h06, 1, 0, 1, 0, 32'h0, 5, 0, 0));
        vq.push_back(mk(0, 8'h00, 0, 0, 0, 1, 32'h00000605, 6, 0, 0));
        vq.push_back(mk(0, 8'h00, 0, 0, 0, 0, 32'h0, 6, 1, 0));
        run_vecs("t2_partial");

        // FIFO full during cycles 3-7: stall only while a word is pending.
        hard_rst("arst_a");
        en = 1'b1;
        vq.push_back(mk(1, 8'h01, 0, 0, 1, 0, 32'h0, 0, 0, 0));
        vq.push_back(mk(1, 8'h02, 0, 0, 1, 0, 32'h0, 1, 0, 0));
        vq.push_back(mk(1, 8'h03, 0, 0, 1, 0, 32'h0, 2, 0, 0));
        vq.push_back(mk(1, 8'h04, 0, 1, 1, 0, 32'h0, 3, 0, 0));
        for (int c = 4; c <= 7; c++)
            vq.push_back(mk(1, 8'h05, 0, 1, 0, 0, 32'h0, 4, 0, 0));
        vq.push_back(mk(1, 8'h05, 0, 0, 1, 1, 32'h04030201, 4, 0, 0));
        vq.push_back(mk(1, 8'h06, 0, 0, 1, 0, 32'h0, 5, 0, 0));
        vq.push_back(mk(1, 8'h07, 0, 0, 1, 0, 32'h0, 6, 0, 0));
        vq.push_back(mk(1, 8'h08, 1, 0, 1, 0, 32'h0, 7, 0, 0));
        vq.push_back(mk(0, 8'h00, 0, 0, 0, 1, 32'h08070605, 8, 0, 0));
        vq.push_back(mk(0, 8'h00, 0, 0, 0, 0, 32'h0, 8, 1, 0));
        run_vecs("t3_full_stall");

        // max_len = 5 on a frame with no tlast: truncation.
        hard_rst("arst_b");
        en = 1'b1;
        max_len = 16'd5;
        vq.push_back(mk(1, 8'h01, 0, 0, 1, 0, 32'h0, 0, 0, 0));
        vq.push_back(mk(1, 8'h02, 0, 0, 1, 0, 32'h0, 1, 0, 0));
        vq.push_back(mk(1, 8'h03, 0, 0, 1, 0, 32'h0, 2, 0, 0));
        vq.push_back(mk(1, 8'h04, 0, 0, 1, 0, 32'h0, 3, 0, 0));
        vq.push_back(mk(1, 8'h05, 0, 0, 1, 1, 32'h04030201, 4, 0, 0));
        vq.push_back(mk(1, 8'h06, 0, 0, 0, 1, 32'h00000005, 5, 0, 1));
        vq.push_back(mk(1, 8'h06, 0, 0, 0, 0, 32'h0, 5, 1, 1));
        vq.push_back(mk(1, 8'h06, 0, 0, 0, 0, 32'h0, 5, 1, 1));
        run_vecs("t4_maxlen");
        hard_rst("arst_c");
        max_len = 16'd0;

        // RATIO=1: 16 back-to-back beats, each written the following cycle.
        en1 = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            if (i < 16) begin
                bus1.axis_tvalid = 1'b1;
                bus1.axis_tdata  = 8'(8'h10 + i);
                bus1.axis_tlast  = (i == 15);
            end else begin
                bus1.axis_tvalid = 1'b0;
                bus1.axis_tlast  = 1'b0;
            end
            #1;
            chk($sformatf("r1[%0d] tready", i), 32'(bus1.axis_tready), 32'(i < 16));
            chk($sformatf("r1[%0d] write", i), 32'(bus1.fifo_write), 32'(i > 0));
            if (i > 0) chk($sformatf("r1[%0d] wdata", i), 32'(bus1.fifo_wdata), 32'(8'(8'h0F + i)));
            chk($sformatf("r1[%0d] len", i), 32'(len1), 32'(i));
        end
        @(negedge clk);
        #1;
        chk("r1 done", 32'(done1), 32'd1);
        chk("r1 final write", 32'(bus1.fifo_write), 32'd0);
        en1 = 1'b0;

        // Async reset after 3 beats drops the partial word; next frame starts at lane 0.
        en = 1'b1;
        vq.push_back(mk(1, 8'h01, 0, 0, 1, 0, 32'h0, 0, 0, 0));
        vq.push_back(mk(1, 8'h02, 0, 0, 1, 0, 32'h0, 1, 0, 0));
        vq.push_back(mk(1, 8'h03, 0, 0, 1, 0, 32'h0, 2, 0, 0));
        run_vecs("t6_pre");
        hard_rst("arst_mid");
        en = 1'b1;
        vq.push_back(mk(1, 8'hAA, 0, 0, 1, 0, 32'h0, 0, 0, 0));
        vq.push_back(mk(1, 8'hBB, 0, 0, 1, 0, 32'h0, 1, 0, 0));
        vq.push_back(mk(1, 8'hCC, 0, 0, 1, 0, 32'h0, 2, 0, 0));
        vq.push_back(mk(1, 8'hDD, 1, 0, 1, 0, 32'h0, 3, 0, 0));
        vq.push_back(mk(0, 8'h00, 0, 0, 0, 1, 32'hDDCCBBAA, 4, 0, 0));
        vq.push_back(mk(0, 8'h00, 0, 0, 0, 0, 32'h0, 4, 1, 0));
        run_vecs("t6_post");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
